// File: rtl/imem_loader.sv
// Serial program loader: parses A5/N/data/checksum frames from a byte stream into
// instruction-memory writes and holds the CPU stalled until a verified program is resident.
module imem_loader (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   input  logic        reload_en,
   output logic        imem_we,
   output logic [7:0]  imem_addr,
   output logic [31:0] imem_wdata,
   output logic        cpu_hold,
   output logic        done,
   output logic        err
);

   localparam logic [7:0] HEADER = 8'hA5;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CNT,
      S_DATA,
      S_CSUM,
      S_DONE,
      S_ERR
   } state_t;

   state_t      state, state_next;
   logic [7:0]  word_cnt;
   logic [7:0]  word_idx;
   logic [1:0]  byte_idx;
   logic [23:0] asm_q;
   logic [7:0]  csum;
   logic        accept;
   logic        last_byte_of_word;
   logic        last_word;

   assign accept            = rx_valid & rx_ready;
   assign last_byte_of_word = (byte_idx == 2'd3);
   assign last_word         = (word_idx == word_cnt - 8'd1);

   // Status is a pure function of state, so it flips on the same edge as the transition.
   assign cpu_hold = (state != S_DONE);
   assign done     = (state == S_DONE);
   assign err      = (state == S_ERR);

   // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      rx_ready   = 1'b0;
      state_next = state;
      if (!rst) begin
         rx_ready = (state == S_DONE) ? reload_en : 1'b1;
      end
      if (accept) begin
         case (state)
            S_IDLE: if (rx_data == HEADER) state_next = S_CNT;
            S_CNT:  state_next = (rx_data == 8'd0) ? S_ERR : S_DATA;
            S_DATA: if (last_byte_of_word && last_word) state_next = S_CSUM;
            S_CSUM: state_next = (rx_data == csum) ? S_DONE : S_ERR;
            S_DONE: if (rx_data == HEADER) state_next = S_CNT;
            S_ERR:  if (rx_data == HEADER) state_next = S_CNT;
            default: state_next = S_IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_cnt   <= 8'd0;
         word_idx   <= 8'd0;
         byte_idx   <= 2'd0;
         asm_q      <= 24'd0;
         csum       <= 8'd0;
         imem_we    <= 1'b0;
         imem_addr  <= 8'd0;
         imem_wdata <= 32'd0;
      end else begin
         imem_we <= 1'b0;
         if (accept) begin
            case (state)
               S_CNT: begin
                  word_cnt <= rx_data;
                  word_idx <= 8'd0;
                  byte_idx <= 2'd0;
                  csum     <= 8'd0;
               end
               S_DATA: begin
                  // The assembly register is separate from imem_wdata, so bytes can stream without a stall.
                  asm_q    <= {asm_q[15:0], rx_data};
                  csum     <= csum ^ rx_data;
                  byte_idx <= byte_idx + 2'd1;
                  if (last_byte_of_word) begin
                     imem_we    <= 1'b1;
                     imem_addr  <= word_idx;
                     imem_wdata <= {asm_q, rx_data};
                     word_idx   <= word_idx + 8'd1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
